// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode-side, forwarding-source and ALU-side signals around the
// ID/EX operand stage; the stage itself connects through the slave modport.
interface id_ex_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);
  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic [RA_W-1:0]  id_rd;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [WIDTH-1:0] id_imm;
  logic             id_alu_src;
  logic [2:0]       id_alu_ctrl;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_mem_to_reg;
  logic             stall;
  logic             flush;
  logic             exmem_reg_write;
  logic [RA_W-1:0]  exmem_rd;
  logic [WIDTH-1:0] exmem_result;
  logic             memwb_reg_write;
  logic [RA_W-1:0]  memwb_rd;
  logic [WIDTH-1:0] memwb_result;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] ex_store_data;
  logic [RA_W-1:0]  ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_mem_to_reg;
  logic             ex_valid;
  logic             load_use_stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, stall, flush, exmem_reg_write, exmem_rd,
           exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid,
           load_use_stall, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, stall, flush, exmem_reg_write, exmem_rd,
           exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid,
           load_use_stall, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use bubble insertion; drives the ALU operands and opcode.
`ifndef ALU_OFF
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_SLT 3'd5
`define ALU_SLL 3'd6
`define ALU_OFF 3'd7
`endif

module id_ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input logic clk,
  input logic rst,
  id_ex_operand_stage_if.slave bus
);
  localparam logic [2:0] ALU_OFF_C = `ALU_OFF;

  typedef struct packed {
    logic             valid;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [RA_W-1:0]  rd;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
    logic             alu_src;
    logic [2:0]       alu_ctrl;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
  } stage_t;

  stage_t           ex_q, ex_d, bubble, captured;
  logic             load_use;
  logic [1:0]       sel_a, sel_b;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & bus.id_valid &
                    ((ex_q.rd == bus.id_rs) | (ex_q.rd == bus.id_rt));

  // Bubbles also clear rs/rt so an empty slot never matches a forwarding source.
  always_comb begin
    bubble          = '0;
    bubble.alu_ctrl = ALU_OFF_C;

    captured.valid      = bus.id_valid;
    captured.rs         = bus.id_rs;
    captured.rt         = bus.id_rt;
    captured.rd         = bus.id_rd;
    captured.rs_data    = bus.id_rs_data;
    captured.rt_data    = bus.id_rt_data;
    captured.imm        = bus.id_imm;
    captured.alu_src    = bus.id_alu_src;
    captured.alu_ctrl   = bus.id_alu_ctrl;
    captured.reg_write  = bus.id_reg_write;
    captured.mem_read   = bus.id_mem_read;
    captured.mem_write  = bus.id_mem_write;
    captured.mem_to_reg = bus.id_mem_to_reg;

    if (bus.flush)      ex_d = bubble;
    else if (bus.stall) ex_d = ex_q;
    else if (load_use)  ex_d = bubble;
    else                ex_d = captured;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q          <= '0;
      ex_q.alu_ctrl <= ALU_OFF_C;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_comb begin
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_q.rs)) begin
      sel_a = 2'b10;
      fwd_a = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_q.rs)) begin
      sel_a = 2'b01;
      fwd_a = bus.memwb_result;
    end else begin
      sel_a = 2'b00;
      fwd_a = ex_q.rs_data;
    end
  end

  always_comb begin
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_q.rt)) begin
      sel_b = 2'b10;
      fwd_b = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_q.rt)) begin
      sel_b = 2'b01;
      fwd_b = bus.memwb_result;
    end else begin
      sel_b = 2'b00;
      fwd_b = ex_q.rt_data;
    end
  end

  assign bus.alu_a          = fwd_a;
  assign bus.ex_store_data  = fwd_b;
  assign bus.alu_b          = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign bus.alu_ctrl       = ex_q.valid ? ex_q.alu_ctrl : ALU_OFF_C;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.load_use_stall = load_use;
  assign bus.fwd_a_sel      = sel_a;
  assign bus.fwd_b_sel      = sel_b;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus a
// randomized run compared against an instruction-level reference model.
module tb_id_ex_operand_stage;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_OFF = 3'd7;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  id_ex_operand_stage_if #(.WIDTH(32), .RA_W(5)) bus ();
  id_ex_operand_stage #(.WIDTH(32), .RA_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        src;
    logic [2:0]  ctrl;
    logic        rw, mr, mw, m2r;
  } inst_t;

  inst_t m;

  function automatic inst_t bub();
    inst_t b;
    b      = '0;
    b.ctrl = ALU_OFF;
    return b;
  endfunction

  function automatic logic exp_lus();
    return m.v && m.mr && (m.rd != 0) && bus.id_valid &&
           (m.rd == bus.id_rs || m.rd == bus.id_rt);
  endfunction

  function automatic logic [33:0] fwd_model(input logic [4:0] r, input logic [31:0] d);
    if (r != 0 && bus.exmem_reg_write && bus.exmem_rd == r) return {2'b10, bus.exmem_result};
    if (r != 0 && bus.memwb_reg_write && bus.memwb_rd == r) return {2'b01, bus.memwb_result};
    return {2'b00, d};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)            m <= bub();
    else if (bus.flush)  m <= bub();
    else if (bus.stall)  m <= m;
    else if (exp_lus())  m <= bub();
    else m <= '{v: bus.id_valid, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                rsd: bus.id_rs_data, rtd: bus.id_rt_data, imm: bus.id_imm,
                src: bus.id_alu_src, ctrl: bus.id_alu_ctrl, rw: bus.id_reg_write,
                mr: bus.id_mem_read, mw: bus.id_mem_write, m2r: bus.id_mem_to_reg};
  end

  task automatic drive_id(input logic v, input logic [4:0] rs, rt, rd,
                          input logic [31:0] rsd, rtd, imm, input logic src,
                          input logic [2:0] ctrl, input logic rw, mr, mw, m2r);
    bus.id_valid = v;   bus.id_rs = rs;   bus.id_rt = rt;   bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.id_alu_src = src; bus.id_alu_ctrl = ctrl;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_mem_to_reg = m2r;
  endtask

  task automatic drive_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wr);
    bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = er;
    bus.memwb_reg_write = ww; bus.memwb_rd = wrd; bus.memwb_result = wr;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    drive_id(1, 1, 2, 3, 32'hAA, 32'hBB, 32'hCC, 0, ALU_SUB, 1, 1, 1, 1);
    drive_fwd(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus.alu_a, bus.alu_b, bus.ex_store_data} !== 96'd0) begin fails++;
      $display("FAIL reset_data: got %h %h %h expected 0", bus.alu_a, bus.alu_b, bus.ex_store_data); end
    checks++; if (bus.alu_ctrl !== ALU_OFF) begin fails++;
      $display("FAIL reset_ctrl: got %0d expected %0d", bus.alu_ctrl, ALU_OFF); end
    checks++; if ({bus.ex_valid, bus.load_use_stall, bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_rd,
                   bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg} !== 15'd0) begin
      fails++; $display("FAIL reset_ctrlbits: got valid=%b lus=%b sel=%b/%b rd=%0d expected all 0",
                        bus.ex_valid, bus.load_use_stall, bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_rd); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_capture();
    @(negedge clk);
    drive_id(1, 1, 2, 3, 8, 41, 0, 0, ALU_SUB, 1, 0, 0, 0);
    @(posedge clk); #1;
    checks++; if (bus.alu_a !== 32'd8 || bus.alu_b !== 32'd41) begin fails++;
      $display("FAIL capture_ops: got a=%0d b=%0d expected a=8 b=41", bus.alu_a, bus.alu_b); end
    checks++; if (bus.alu_ctrl !== ALU_SUB || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd3) begin fails++;
      $display("FAIL capture_ctrl: got ctrl=%0d valid=%b rd=%0d expected ctrl=1 valid=1 rd=3",
               bus.alu_ctrl, bus.ex_valid, bus.ex_rd); end
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    drive_id(1, 3, 3, 4, 11, 22, 77, 1, ALU_ADD, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0);
    drive_fwd(1, 3, 100, 1, 3, 200);
    #1;
    checks++; if (bus.alu_a !== 32'd100 || bus.fwd_a_sel !== 2'b10) begin fails++;
      $display("FAIL fwd_exmem_a: got a=%0d sel=%b expected a=100 sel=10", bus.alu_a, bus.fwd_a_sel); end
    checks++; if (bus.alu_b !== 32'd77 || bus.ex_store_data !== 32'd100 || bus.fwd_b_sel !== 2'b10) begin fails++;
      $display("FAIL fwd_exmem_b: got b=%0d st=%0d sel=%b expected b=77 st=100 sel=10",
               bus.alu_b, bus.ex_store_data, bus.fwd_b_sel); end
    bus.exmem_reg_write = 1'b0;
    #1;
    checks++; if (bus.alu_a !== 32'd200 || bus.fwd_a_sel !== 2'b01 || bus.ex_store_data !== 32'd200) begin fails++;
      $display("FAIL fwd_memwb: got a=%0d sel=%b st=%0d expected a=200 sel=01 st=200",
               bus.alu_a, bus.fwd_a_sel, bus.ex_store_data); end
    drive_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reg0();
    @(negedge clk);
    drive_id(1, 0, 0, 6, 0, 0, 0, 0, ALU_ADD, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive_fwd(1, 0, 55, 1, 0, 66);
    #1;
    checks++; if (bus.alu_a !== 32'd0 || bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin fails++;
      $display("FAIL reg0_nofwd: got a=%0d sel=%b/%b expected a=0 sel=00/00",
               bus.alu_a, bus.fwd_a_sel, bus.fwd_b_sel); end
    drive_fwd(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_id(1, 1, 2, 5, 0, 0, 4, 1, ALU_ADD, 1, 1, 0, 1);
    @(posedge clk);
    @(negedge clk);
    drive_id(1, 5, 7, 8, 0, 0, 0, 0, ALU_SUB, 1, 0, 0, 0);
    #1;
    checks++; if (bus.load_use_stall !== 1'b1) begin fails++;
      $display("FAIL lu_detect: got %b expected 1", bus.load_use_stall); end
    @(posedge clk); #1;
    checks++; if (bus.ex_valid !== 1'b0 || bus.alu_ctrl !== ALU_OFF || bus.load_use_stall !== 1'b0) begin fails++;
      $display("FAIL lu_bubble: got valid=%b ctrl=%0d lus=%b expected 0 7 0",
               bus.ex_valid, bus.alu_ctrl, bus.load_use_stall); end
    @(posedge clk); #1;
    checks++; if (bus.ex_valid !== 1'b1 || bus.alu_ctrl !== ALU_SUB || bus.ex_rd !== 5'd8) begin fails++;
      $display("FAIL lu_resume: got valid=%b ctrl=%0d rd=%0d expected 1 1 8",
               bus.ex_valid, bus.alu_ctrl, bus.ex_rd); end
    @(negedge clk);
    drive_id(1, 1, 2, 0, 0, 0, 0, 1, ALU_ADD, 1, 1, 0, 1);
    @(posedge clk);
    @(negedge clk);
    drive_id(1, 0, 0, 9, 0, 0, 0, 0, ALU_ADD, 1, 0, 0, 0);
    #1;
    checks++; if (bus.load_use_stall !== 1'b0) begin fails++;
      $display("FAIL lu_rd0: got %b expected 0", bus.load_use_stall); end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    drive_id(1, 1, 2, 9, 32'h1234, 32'h5678, 0, 0, ALU_XOR, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1, 5'(i + 3), 5'(i + 4), 5'(i + 10), $urandom, $urandom, $urandom, 1, ALU_SUB, 0, 1, 1, 1);
      @(posedge clk); #1;
      checks++; if (bus.alu_a !== 32'h1234 || bus.alu_b !== 32'h5678 || bus.alu_ctrl !== ALU_XOR ||
                    bus.ex_rd !== 5'd9 || bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b0) begin fails++;
        $display("FAIL stall_hold%0d: got a=%h b=%h ctrl=%0d rd=%0d v=%b expected 1234 5678 4 9 1",
                 i, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.ex_rd, bus.ex_valid); end
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ex_valid !== 1'b0 || bus.alu_ctrl !== ALU_OFF || bus.ex_rd !== 5'd0 ||
                  bus.ex_reg_write !== 1'b0) begin fails++;
      $display("FAIL flush_over_stall: got v=%b ctrl=%0d rd=%0d rw=%b expected 0 7 0 0",
               bus.ex_valid, bus.alu_ctrl, bus.ex_rd, bus.ex_reg_write); end
    @(negedge clk);
    bus.flush = 1'b0; bus.stall = 1'b0;
    drive_id(1, 1, 2, 5, 0, 0, 0, 1, ALU_ADD, 1, 1, 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.stall = 1'b1;
    drive_id(1, 6, 5, 7, 0, 0, 0, 0, ALU_SUB, 1, 0, 0, 0);
    @(posedge clk); #1;
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b1 || bus.load_use_stall !== 1'b1) begin fails++;
      $display("FAIL stall_with_lu: got v=%b mr=%b lus=%b expected 1 1 1",
               bus.ex_valid, bus.ex_mem_read, bus.load_use_stall); end
    @(negedge clk);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.ex_valid !== 1'b0 || bus.load_use_stall !== 1'b0) begin fails++;
      $display("FAIL lu_after_stall: got v=%b lus=%b expected 0 0", bus.ex_valid, bus.load_use_stall); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive_id(1, 1, 2, 3, 32'hDEAD, 32'hBEEF, 0, 0, ALU_SUB, 1, 0, 1, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.ex_valid !== 1'b0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 ||
                  bus.alu_ctrl !== ALU_OFF || bus.ex_mem_write !== 1'b0) begin fails++;
      $display("FAIL async_reset: got v=%b a=%h b=%h ctrl=%0d mw=%b expected 0 0 0 7 0",
               bus.ex_valid, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.ex_mem_write); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [33:0] fa, fb;
    logic [31:0] eb;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.stall = $urandom_range(0, 7) == 0;
      bus.flush = $urandom_range(0, 11) == 0;
      drive_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      @(posedge clk); #1;
      fa = fwd_model(m.rs, m.rsd);
      fb = fwd_model(m.rt, m.rtd);
      eb = m.src ? m.imm : fb[31:0];
      checks++; if ({bus.ex_valid, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                     bus.ex_mem_to_reg} !== {m.v, m.rd, m.rw, m.mr, m.mw, m.m2r}) begin fails++;
        $display("FAIL rnd_ctrl[%0d]: got v=%b rd=%0d rw/mr/mw/m2r=%b%b%b%b expected v=%b rd=%0d %b%b%b%b", n,
                 bus.ex_valid, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                 bus.ex_mem_to_reg, m.v, m.rd, m.rw, m.mr, m.mw, m.m2r); end
      checks++; if (bus.alu_ctrl !== (m.v ? m.ctrl : ALU_OFF) || bus.load_use_stall !== exp_lus()) begin fails++;
        $display("FAIL rnd_op[%0d]: got ctrl=%0d lus=%b expected ctrl=%0d lus=%b", n,
                 bus.alu_ctrl, bus.load_use_stall, m.v ? m.ctrl : ALU_OFF, exp_lus()); end
      if (m.v) begin
        checks++; if (bus.alu_a !== fa[31:0] || bus.fwd_a_sel !== fa[33:32] || bus.fwd_b_sel !== fb[33:32] ||
                      bus.ex_store_data !== fb[31:0] || bus.alu_b !== eb) begin fails++;
          $display("FAIL rnd_data[%0d]: got a=%h sa=%b b=%h st=%h sb=%b expected a=%h sa=%b b=%h st=%h sb=%b", n,
                   bus.alu_a, bus.fwd_a_sel, bus.alu_b, bus.ex_store_data, bus.fwd_b_sel,
                   fa[31:0], fa[33:32], eb, fb[31:0], fb[33:32]); end
      end
    end
    @(negedge clk);
    bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_capture();
    test_fwd_priority();
    test_reg0();
    test_load_use();
    test_stall_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
